// File: rtl/seq_pkg.sv
// Shared constants for the sequential-circuit set: serializer state encodings
// and the default word width used by the serializer and the detectors.
package seq_pkg;

   localparam int SEQ_DEFAULT_WIDTH = 8;

   // One-hot serializer states
   localparam logic [1:0] SER_IDLE  = 2'b01;
   localparam logic [1:0] SER_SHIFT = 2'b10;

endpackage

// File: rtl/seq_hold_reg.sv
// One-word holding buffer for the serializer: a WIDTH-bit data register plus
// a full flag, with load/take/clear controls.
module seq_hold_reg
   import seq_pkg::*;
#(
   parameter int WIDTH = SEQ_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic             take,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_q,
   output logic             full_q
);

   logic [WIDTH-1:0] data_d;
   logic             full_d;

   // A load on the same edge as a take refills the buffer, so load wins.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (clear) begin
         data_d = '0;
         full_d = 1'b0;
      end else if (load) begin
         data_d = data_in;
         full_d = 1'b1;
      end else if (take) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words on a valid/ready
// handshake and emits one registered bit per clock, gap-free between words.
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH     = SEQ_DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             seq_out,
   output logic             seq_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             seq_out_q, seq_out_d;
   logic             seq_valid_q, seq_valid_d;
   logic             word_done_q, word_done_d;
   logic             hold_load_s, hold_take_s;
   logic [WIDTH-1:0] hold_data_s;
   logic             hold_full_s;
   logic             accept_s;

   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
      else           return {1'b0, w[WIDTH-1:1]};
   endfunction

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) return w[WIDTH-1];
      else           return w[0];
   endfunction

   assign accept_s = load_valid & ~hold_full_s;

   seq_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .load    (hold_load_s),
      .take    (hold_take_s),
      .data_in (data_in),
      .data_q  (hold_data_s),
      .full_q  (hold_full_s)
   );

   // FSM, shift register and bit counter; the last-bit edge chains the next word.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      hold_load_s = 1'b0;
      hold_take_s = 1'b0;
      if (clear) begin
         state_d = SER_IDLE;
         cnt_d   = '0;
         shreg_d = '0;
      end else begin
         case (state_q)
            SER_IDLE: begin
               if (accept_s) begin
                  shreg_d = data_in;
                  cnt_d   = '0;
                  state_d = SER_SHIFT;
               end else begin
                  state_d = SER_IDLE;
               end
            end
            SER_SHIFT: begin
               if (cnt_q != CNT_LAST) begin
                  shreg_d     = shift_word(shreg_q);
                  cnt_d       = cnt_q + CW'(1);
                  hold_load_s = accept_s;
               end else if (hold_full_s) begin
                  shreg_d     = hold_data_s;
                  cnt_d       = '0;
                  hold_take_s = 1'b1;
                  hold_load_s = accept_s;
               end else if (accept_s) begin
                  shreg_d = data_in;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = '0;
                  state_d = SER_IDLE;
               end
            end
            default: begin
               state_d = SER_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // seq_out keeps its last value whenever no word is being shifted.
   always_comb begin
      seq_valid_d = (state_d == SER_SHIFT);
      word_done_d = seq_valid_d && (cnt_d == CNT_LAST);
      if (clear) begin
         seq_out_d = 1'b0;
      end else if (seq_valid_d) begin
         seq_out_d = first_bit(shreg_d);
      end else begin
         seq_out_d = seq_out_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SER_IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         seq_out_q   <= 1'b0;
         seq_valid_q <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         seq_out_q   <= seq_out_d;
         seq_valid_q <= seq_valid_d;
         word_done_q <= word_done_d;
      end
   end

   assign load_ready = ~hold_full_s;
   assign busy       = (state_q == SER_SHIFT) | hold_full_s;
   assign seq_out    = seq_out_q;
   assign seq_valid  = seq_valid_q;
   assign word_done  = word_done_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: default MSB-first 8-bit instance plus
// a 4-bit LSB-first instance.
module tb_seq_bit_serializer;

   logic       clk = 1'b0;
   logic       reset, clear;
   logic [7:0] data_in;
   logic       load_valid;
   logic       load_ready, seq_out, seq_valid, word_done, busy;
   logic [3:0] d4;
   logic       lv4;
   logic       load_ready4, seq_out4, seq_valid4, word_done4, busy4;

   int checks = 0;
   int errors = 0;
   int det_hits;
   logic [2:0]  hist;
   logic [7:0]  w8;
   logic [15:0] s16;
   logic [23:0] s24;
   logic [3:0]  w4;

   always #5 clk = ~clk;

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .clear(clear), .data_in(data_in),
      .load_valid(load_valid), .load_ready(load_ready), .seq_out(seq_out),
      .seq_valid(seq_valid), .word_done(word_done), .busy(busy)
   );

   seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
      .clk(clk), .reset(reset), .clear(clear), .data_in(d4),
      .load_valid(lv4), .load_ready(load_ready4), .seq_out(seq_out4),
      .seq_valid(seq_valid4), .word_done(word_done4), .busy(busy4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_bit(input string tag, input logic b, input logic d);
      chk({tag, "_out"}, {31'd0, seq_out}, {31'd0, b});
      chk({tag, "_valid"}, {31'd0, seq_valid}, 32'd1);
      chk({tag, "_done"}, {31'd0, word_done}, {31'd0, d});
   endtask

   task automatic chk_idle(input string tag, input logic exp_out);
      chk({tag, "_out"}, {31'd0, seq_out}, {31'd0, exp_out});
      chk({tag, "_valid"}, {31'd0, seq_valid}, 32'd0);
      chk({tag, "_done"}, {31'd0, word_done}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_ready"}, {31'd0, load_ready}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; clear = 1'b0; data_in = 8'h00; load_valid = 1'b0;
      d4 = 4'h0; lv4 = 1'b0;
      @(negedge clk); @(negedge clk);
      chk_idle("rst", 1'b0);
      chk("rst_valid4", {31'd0, seq_valid4}, 32'd0);
      reset = 1'b0;
      step();

      // Test 1: 8'hB6, with a "110" watcher on the serial stream
      w8 = 8'hB6; det_hits = 0; hist = 3'b000;
      data_in = w8; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk_bit($sformatf("t1_b%0d", i), w8[7-i], (i == 7));
         chk($sformatf("t1_busy%0d", i), {31'd0, busy}, 32'd1);
         hist = {hist[1:0], seq_out};
         if (i >= 2 && hist == 3'b110) det_hits++;
         step();
      end
      chk_idle("t1_end", 1'b0);
      chk("t1_det110", det_hits, 32'd2);

      // Test 2: F0 then 0F back-to-back
      s16 = 16'hF00F;
      data_in = 8'hF0; load_valid = 1'b1;
      step();
      chk("t2_ready", {31'd0, load_ready}, 32'd1);
      data_in = 8'h0F; load_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk_bit($sformatf("t2_b%0d", i), s16[15-i], (i == 7) || (i == 15));
         step();
         load_valid = 1'b0;
      end
      chk_idle("t2_end", 1'b1);

      // Test 3: three words, second held, third waits for the buffer
      s24 = 24'hC35A96;
      data_in = 8'hC3; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < 24; i++) begin
         chk_bit($sformatf("t3_b%0d", i), s24[23-i], (i % 8) == 7);
         chk($sformatf("t3_ready%0d", i), {31'd0, load_ready},
             {31'd0, !((i >= 1 && i <= 7) || (i >= 9 && i <= 15))});
         if (i == 0) begin data_in = 8'h5A; load_valid = 1'b1; end
         if (i == 1) begin data_in = 8'h96; load_valid = 1'b1; end
         if (i == 9) load_valid = 1'b0;
         step();
      end
      chk_idle("t3_end", 1'b0);

      // Test 4: async reset between edges at bit 3 of 8'hAA
      w8 = 8'hAA;
      data_in = w8; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_bit($sformatf("t4_b%0d", i), w8[7-i], 1'b0);
         step();
      end
      chk_bit("t4_b3", w8[4], 1'b0);
      #2 reset = 1'b1;
      #1 chk_idle("t4_rst", 1'b0);
      @(negedge clk);
      reset = 1'b0;
      chk_idle("t4_rel", 1'b0);
      w8 = 8'h01;
      data_in = w8; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk_bit($sformatf("t4n_b%0d", i), w8[7-i], (i == 7));
         step();
      end
      chk_idle("t4_end", 1'b1);

      // Test 5: clear with load_valid on the last-bit edge
      w8 = 8'h3C;
      data_in = w8; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk_bit($sformatf("t5_b%0d", i), w8[7-i], (i == 7));
         if (i == 7) begin clear = 1'b1; data_in = 8'hE7; load_valid = 1'b1; end
         step();
      end
      clear = 1'b0; load_valid = 1'b0;
      chk_idle("t5_clr", 1'b0);
      step();
      chk_idle("t5_drop", 1'b0);

      // Test 6: WIDTH=4, LSB first, 4'b0011
      w4 = 4'b0011;
      d4 = w4; lv4 = 1'b1;
      step();
      lv4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t6_out%0d", i), {31'd0, seq_out4}, {31'd0, w4[i]});
         chk($sformatf("t6_valid%0d", i), {31'd0, seq_valid4}, 32'd1);
         chk($sformatf("t6_done%0d", i), {31'd0, word_done4}, {31'd0, (i == 3)});
         step();
      end
      chk("t6_end_valid", {31'd0, seq_valid4}, 32'd0);
      chk("t6_end_busy", {31'd0, busy4}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
